iodelay_calib: RTL and testbench
================================

# iodelay_calib

Training controller for the MIPI per-lane `iodelay` tap line. On request it sweeps every tap, checks the delayed lane bit against the expected training bit, and finds the longest contiguous passing window. It then writes the window centre into `iodelay` through its `in_delay`/`in_delay_we` port. One instance sits beside each lane's `iodelay`, driven by the lane training sequencer.

## Interface
- `P_DELAY_NBIT`, default `MIPI_IODELAY_NBIT` (5): tap index width; tap count T = 2^P_DELAY_NBIT.
- `P_SETTLE`, default T+2 (34): cycles waited after a tap write before checking. Must be ≥ T so the `iodelay` shift line refills.
- `P_CHECK_LEN`, default 64: compare cycles per tap.
- `P_DEFAULT_TAP`, default 16: tap written when no window is found.

Ports:
- `clk`  in  1  Sole clock. Same domain as `iodelay`.
- `rst_n`  in  1  Synchronous, active-low reset.
- `in_start`  in  1  Start calibration. Sampled only in IDLE.
- `in_dio`  in  1  Delayed lane bit (`iodelay.out_dio`).
- `in_ref`  in  1  Expected training bit, cycle-aligned with `in_dio` at the correct tap.
- `out_delay`  out  P_DELAY_NBIT  Tap value to `iodelay.in_delay`.
- `out_delay_we`  out  1  One-cycle write strobe to `iodelay.in_delay_we`.
- `out_busy`  out  1  High from the first SET through DONE.
- `out_done`  out  1  One-cycle pulse at completion.
- `out_fail`  out  1  Sticky: no passing tap. Cleared on the next start.
- `out_win_len`  out  P_DELAY_NBIT+1  Length of the chosen window (0..T).

## Operation
- States and transitions:
  - IDLE: `in_start`=1 → SET. Clears tap, err, run and best, and clears `out_fail`.
  - SET: drives `out_delay`=tap and `out_delay_we`=1 → SETTLE.
  - SETTLE: counts P_SETTLE cycles → CHECK.
  - CHECK: runs P_CHECK_LEN cycles. Any cycle with `in_dio`≠`in_ref` sets err → EVAL.
  - EVAL: tap passes iff err=0.
    - Pass: if run_len=0 then run_start=tap; run_len+1.
    - Fail: close the run, then run_len=0.
    - Closing a run: if run_len > best_len (strictly), best_start=run_start and best_len=run_len. The first of equal-length windows wins.
    - At tap=T-1 the open run is closed in the same cycle → APPLY. Otherwise tap+1 and err=0 → SET.
  - APPLY: if best_len=0, drive `out_delay`=P_DEFAULT_TAP and set `out_fail`; otherwise `out_delay`=best_start+((best_len-1)>>1). `out_delay_we`=1, `out_win_len`=best_len → DONE.
  - DONE: `out_done`=1 → IDLE.
- Arithmetic: run_len and best_len are P_DELAY_NBIT+1 bits, so T is representable. Centre arithmetic is P_DELAY_NBIT+1 bits, truncated to P_DELAY_NBIT; the result is always ≤ T-1. The tap counter never wraps within a scan.
- `in_start` while busy is ignored. No restart and no queuing.
- `out_delay` holds its last written value between strobes.
- Reset mid-scan: all state and outputs return to reset values the next cycle. No strobe is issued. `iodelay` keeps whatever tap it last received.

## Timing
- Reset values: state IDLE; `out_delay`=P_DEFAULT_TAP; `out_delay_we`, `out_busy`, `out_done`, `out_fail`=0; `out_win_len`=0.
- All outputs are registered. With `in_start` sampled at edge k, `out_delay_we`=1 for tap 0 during cycle k+1.
- Per tap: 1 + P_SETTLE + P_CHECK_LEN + 1 cycles (100 at defaults).
- Total from start sample to `out_done`: T·(2+P_SETTLE+P_CHECK_LEN) + 2 cycles (3202 at defaults).
- The final strobe occurs exactly 1 cycle before `out_done`. `out_busy` drops the cycle after `out_done`.

## Structure
- Shared globals/package holds `MIPI_IODELAY_NBIT`, the default tap (16) and the state encoding constants.
- One sub-module, `iodelay_win_tracker`, holds run/best start+length and the centre computation. Interface: per-tap pass/fail strobe, last-tap flag, clear.
- The FSM and counters stay in `iodelay_calib`.

## Test plan
- `in_ref`=`in_dio` at all taps → best_len=32, `out_delay`=15, `out_fail`=0, done at cycle k+3202.
- Pass only taps 10..20 → `out_win_len`=11, `out_delay`=15.
- Pass taps 3..6 and 20..27 → `out_win_len`=8, `out_delay`=23. Equal windows 2..5 and 9..12 → `out_delay`=3.
- Pass only taps 28..31 (run open at last tap) → `out_delay`=29, `out_win_len`=4.
- No passing tap (single mismatch in every CHECK) → `out_fail`=1, `out_delay`=16, `out_win_len`=0.
- `rst_n` low for one cycle at tap 12, plus `in_start` pulsed while busy: no further strobes, `out_busy`=0 next cycle, reset values; ignored start causes no restart.

Source files
------------

// File: rtl/iodelay_calib_pkg.sv
// Shared constants and FSM state encoding for the per-lane iodelay
// training controller.
package iodelay_calib_pkg;

    localparam int MIPI_IODELAY_NBIT = 5;
    localparam int CALIB_DEFAULT_TAP = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_EVAL   = 3'd4,
        ST_APPLY  = 3'd5,
        ST_DONE   = 3'd6
    } calib_state_t;

endpackage

// File: rtl/iodelay_calib_win_tracker.sv
// Tracks the current and the longest passing tap window during a sweep and
// exposes the window that results once the tap being evaluated is folded in.
module iodelay_win_tracker
    import iodelay_calib_pkg::*;
#(
    parameter int P_DELAY_NBIT = MIPI_IODELAY_NBIT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    eval,
    input  logic                    pass,
    input  logic                    last,
    input  logic [P_DELAY_NBIT-1:0] tap,
    output logic [P_DELAY_NBIT:0]   final_len,
    output logic [P_DELAY_NBIT-1:0] final_centre
);

    localparam logic [P_DELAY_NBIT:0] LEN_ZERO = (P_DELAY_NBIT+1)'(0);
    localparam logic [P_DELAY_NBIT:0] LEN_ONE  = (P_DELAY_NBIT+1)'(1);

    logic [P_DELAY_NBIT-1:0] run_start_r, best_start_r;
    logic [P_DELAY_NBIT:0]   run_len_r, best_len_r;
    logic [P_DELAY_NBIT-1:0] run_start_nxt_s, close_start_s, best_start_nxt_s;
    logic [P_DELAY_NBIT:0]   run_len_nxt_s, close_len_s, best_len_nxt_s;
    logic [P_DELAY_NBIT:0]   centre_wide_s;

    // Next run, the run being closed by this tap, and the resulting best window.
    always_comb begin
        run_start_nxt_s = run_start_r;
        run_len_nxt_s   = LEN_ZERO;
        close_start_s   = run_start_r;
        close_len_s     = LEN_ZERO;
        if (pass) begin
            run_start_nxt_s = (run_len_r == LEN_ZERO) ? tap : run_start_r;
            run_len_nxt_s   = run_len_r + LEN_ONE;
        end else begin
            run_start_nxt_s = run_start_r;
            run_len_nxt_s   = LEN_ZERO;
        end
        // A fail closes the old run; the last tap also closes a run still open after it.
        if (!pass) begin
            close_start_s = run_start_r;
            close_len_s   = run_len_r;
        end else if (last) begin
            close_start_s = run_start_nxt_s;
            close_len_s   = run_len_nxt_s;
        end else begin
            close_start_s = run_start_r;
            close_len_s   = LEN_ZERO;
        end
        if (close_len_s > best_len_r) begin
            best_start_nxt_s = close_start_s;
            best_len_nxt_s   = close_len_s;
        end else begin
            best_start_nxt_s = best_start_r;
            best_len_nxt_s   = best_len_r;
        end
        centre_wide_s = {1'b0, best_start_nxt_s} + ((best_len_nxt_s - LEN_ONE) >> 1);
    end

    assign final_len    = best_len_nxt_s;
    assign final_centre = centre_wide_s[P_DELAY_NBIT-1:0];

    // Run and best registers, updated once per evaluated tap.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            run_start_r  <= {P_DELAY_NBIT{1'b0}};
            run_len_r    <= LEN_ZERO;
            best_start_r <= {P_DELAY_NBIT{1'b0}};
            best_len_r   <= LEN_ZERO;
        end else if (eval) begin
            run_start_r  <= run_start_nxt_s;
            run_len_r    <= run_len_nxt_s;
            best_start_r <= best_start_nxt_s;
            best_len_r   <= best_len_nxt_s;
        end else begin
            run_start_r  <= run_start_r;
            run_len_r    <= run_len_r;
            best_start_r <= best_start_r;
            best_len_r   <= best_len_r;
        end
    end

endmodule

// File: rtl/iodelay_calib.sv
// Per-lane iodelay training controller: sweeps every tap, scores it against the
// training bit and programs the centre of the longest passing window.
module iodelay_calib
    import iodelay_calib_pkg::*;
#(
    parameter int P_DELAY_NBIT  = MIPI_IODELAY_NBIT,
    parameter int P_SETTLE      = (1 << P_DELAY_NBIT) + 2,
    parameter int P_CHECK_LEN   = 64,
    parameter int P_DEFAULT_TAP = CALIB_DEFAULT_TAP
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_start,
    input  logic                    in_dio,
    input  logic                    in_ref,
    output logic [P_DELAY_NBIT-1:0] out_delay,
    output logic                    out_delay_we,
    output logic                    out_busy,
    output logic                    out_done,
    output logic                    out_fail,
    output logic [P_DELAY_NBIT:0]   out_win_len
);

    localparam int CNT_MAX = (P_SETTLE > P_CHECK_LEN) ? P_SETTLE : P_CHECK_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]        SETTLE_LAST = CNT_W'(P_SETTLE - 1);
    localparam logic [CNT_W-1:0]        CHECK_LAST  = CNT_W'(P_CHECK_LEN - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE     = CNT_W'(1);
    localparam logic [P_DELAY_NBIT-1:0] TAP_LAST    = {P_DELAY_NBIT{1'b1}};
    localparam logic [P_DELAY_NBIT-1:0] TAP_ONE     = P_DELAY_NBIT'(1);
    localparam logic [P_DELAY_NBIT-1:0] DEF_TAP     = P_DELAY_NBIT'(P_DEFAULT_TAP);
    localparam logic [P_DELAY_NBIT:0]   LEN_ZERO    = (P_DELAY_NBIT+1)'(0);

    calib_state_t            state_r;
    logic [P_DELAY_NBIT-1:0] tap_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    err_r;
    logic                    clear_s;
    logic                    eval_s;
    logic                    last_s;
    logic [P_DELAY_NBIT:0]   final_len_s;
    logic [P_DELAY_NBIT-1:0] final_centre_s;

    assign clear_s = (state_r == ST_IDLE) && in_start;
    assign eval_s  = (state_r == ST_EVAL);
    assign last_s  = (tap_r == TAP_LAST);

    iodelay_win_tracker #(
        .P_DELAY_NBIT (P_DELAY_NBIT)
    ) u_win (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear_s),
        .eval         (eval_s),
        .pass         (~err_r),
        .last         (last_s),
        .tap          (tap_r),
        .final_len    (final_len_s),
        .final_centre (final_centre_s)
    );

    // Sweep FSM; outputs are registered on entry to the state that owns them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            tap_r        <= {P_DELAY_NBIT{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            err_r        <= 1'b0;
            out_delay    <= DEF_TAP;
            out_delay_we <= 1'b0;
            out_busy     <= 1'b0;
            out_done     <= 1'b0;
            out_fail     <= 1'b0;
            out_win_len  <= LEN_ZERO;
        end else begin
            out_delay_we <= 1'b0;
            out_done     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_start) begin
                        tap_r        <= {P_DELAY_NBIT{1'b0}};
                        err_r        <= 1'b0;
                        out_fail     <= 1'b0;
                        out_delay    <= {P_DELAY_NBIT{1'b0}};
                        out_delay_we <= 1'b1;
                        out_busy     <= 1'b1;
                        state_r      <= ST_SET;
                    end
                end
                ST_SET: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_CHECK;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_CHECK: begin
                    err_r <= err_r | (in_dio ^ in_ref);
                    if (cnt_r == CHECK_LAST) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_EVAL;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_EVAL: begin
                    out_delay_we <= 1'b1;
                    if (last_s) begin
                        // Tracker outputs already include the run this tap closes.
                        out_delay   <= (final_len_s == LEN_ZERO) ? DEF_TAP : final_centre_s;
                        out_fail    <= (final_len_s == LEN_ZERO);
                        out_win_len <= final_len_s;
                        state_r     <= ST_APPLY;
                    end else begin
                        tap_r     <= tap_r + TAP_ONE;
                        err_r     <= 1'b0;
                        out_delay <= tap_r + TAP_ONE;
                        state_r   <= ST_SET;
                    end
                end
                ST_APPLY: begin
                    out_done <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    out_busy <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    out_busy <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iodelay_calib.sv
// Self-checking bench for iodelay_calib: table-driven and random pass maps
// scored against a brute-force window search, plus a mid-scan reset sequence.
module tb_iodelay_calib;

    localparam int T       = 32;
    localparam int S       = T + 2;
    localparam int C       = 64;
    localparam int DEF     = 16;
    localparam int TAP_CYC = 2 + S + C;
    localparam int LIMIT   = T * TAP_CYC + 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_start;
    logic       in_dio;
    logic       in_ref;
    logic [4:0] out_delay;
    logic       out_delay_we;
    logic       out_busy;
    logic       out_done;
    logic       out_fail;
    logic [5:0] out_win_len;

    int n_checks = 0;
    int n_fail   = 0;

    iodelay_calib dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_start     (in_start),
        .in_dio       (in_dio),
        .in_ref       (in_ref),
        .out_delay    (out_delay),
        .out_delay_we (out_delay_we),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_fail     (out_fail),
        .out_win_len  (out_win_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [T-1:0] pass_map;
        int           exp_delay;
        int           exp_len;
        logic         exp_fail;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: try every start tap, extend while passing, keep the first longest.
    task automatic ref_model(input logic [T-1:0] m, output int d, output int len, output logic fail);
        int bs = 0;
        int bl = 0;
        for (int s = 0; s < T; s++) begin
            int l = 0;
            while (s + l < T && m[s + l]) l++;
            if (l > bl) begin
                bl = l;
                bs = s;
            end
        end
        len  = bl;
        fail = (bl == 0);
        d    = (bl == 0) ? DEF : bs + (bl - 1) / 2;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " delay"}, out_delay, DEF);
        chk({tag, " we"}, out_delay_we, 0);
        chk({tag, " busy"}, out_busy, 0);
        chk({tag, " done"}, out_done, 0);
        chk({tag, " fail"}, out_fail, 0);
        chk({tag, " win_len"}, out_win_len, 0);
    endtask

    // Runs one full sweep. Failing taps get one mismatch inside CHECK; passing taps
    // get one mismatch outside CHECK, which must be ignored.
    task automatic run_scan(input logic [T-1:0] pass_map, input int exp_delay,
                            input int exp_len, input logic exp_fail, input string tag);
        int   strobes = 0;
        int   off = 0;
        int   cur = 0;
        int   bad_off = -1;
        int   done_cyc = -1;
        int   busy_drops = 0;
        logic mism;
        @(negedge clk);
        in_start = 1'b1;
        @(posedge clk);
        #1 in_start = 1'b0;
        for (int cyc = 0; cyc < LIMIT && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (out_delay_we) begin
                if (strobes < T) begin
                    chk({tag, " strobe cycle"}, cyc, strobes * TAP_CYC);
                    chk({tag, " strobe tap"}, out_delay, strobes);
                    cur = strobes;
                    off = 0;
                    if (pass_map[cur]) begin
                        case (cur % 4)
                            0: bad_off = S;
                            1: bad_off = S + C + 1;
                            2: bad_off = 0;
                            default: bad_off = $urandom_range(1, S - 1);
                        endcase
                    end else begin
                        case (cur % 3)
                            0: bad_off = S + 1;
                            1: bad_off = S + C;
                            default: bad_off = $urandom_range(S + 2, S + C - 1);
                        endcase
                    end
                end else begin
                    chk({tag, " final strobe cycle"}, cyc, T * TAP_CYC);
                    chk({tag, " final delay"}, out_delay, exp_delay);
                    chk({tag, " final win_len"}, out_win_len, exp_len);
                    chk({tag, " final fail"}, out_fail, exp_fail);
                    bad_off = -1;
                end
                strobes++;
            end else begin
                off++;
            end
            if (cyc == 0) chk({tag, " fail cleared at start"}, out_fail, 0);
            if (!out_busy) busy_drops++;
            mism   = (off == bad_off);
            in_dio = 1'($urandom_range(0, 1));
            in_ref = in_dio ^ mism;
            if (out_done) done_cyc = cyc;
        end
        chk({tag, " done cycle"}, done_cyc, T * TAP_CYC + 1);
        chk({tag, " strobe count"}, strobes, T + 1);
        chk({tag, " busy drops"}, busy_drops, 0);
        chk({tag, " delay at done"}, out_delay, exp_delay);
        chk({tag, " win_len at done"}, out_win_len, exp_len);
        chk({tag, " fail at done"}, out_fail, exp_fail);
        @(negedge clk);
        chk({tag, " busy after done"}, out_busy, 0);
        chk({tag, " done pulse width"}, out_done, 0);
        repeat (5) @(negedge clk);
        chk({tag, " delay held"}, out_delay, exp_delay);
        chk({tag, " fail sticky"}, out_fail, exp_fail);
    endtask

    // Start, poke in_start while busy, then reset for one cycle during tap 12.
    task automatic reset_mid_scan();
        int strobes = 0;
        int after = 0;
        @(negedge clk);
        in_start = 1'b1;
        @(posedge clk);
        #1 in_start = 1'b0;
        for (int cyc = 0; cyc < 13 * TAP_CYC; cyc++) begin
            @(negedge clk);
            in_start = 1'b0;
            if (out_delay_we) begin
                chk("rst strobe cycle", cyc, strobes * TAP_CYC);
                chk("rst strobe tap", out_delay, strobes);
                strobes++;
            end
            in_dio = 1'($urandom_range(0, 1));
            in_ref = in_dio;
            if (cyc == 3 * TAP_CYC + 10) in_start = 1'b1;
            if (cyc == 12 * TAP_CYC + S + 5) begin
                rst_n = 1'b0;
                break;
            end
        end
        chk("rst strobes before reset", strobes, 13);
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_values("rst next cycle");
        for (int cyc = 0; cyc < 3 * TAP_CYC; cyc++) begin
            @(negedge clk);
            if (out_delay_we || out_busy || out_done) after++;
        end
        chk("rst activity after reset", after, 0);
        chk("rst delay kept default", out_delay, DEF);
    endtask

    initial begin
        vec_t vecs[6];
        int   d;
        int   len;
        logic fl;
        logic [T-1:0] m;

        vecs[0] = '{32'hFFFF_FFFF, 15, 32, 1'b0};
        vecs[1] = '{32'h001F_FC00, 15, 11, 1'b0};
        vecs[2] = '{32'h0FF0_0078, 23,  8, 1'b0};
        vecs[3] = '{32'h0000_1E3C,  3,  4, 1'b0};
        vecs[4] = '{32'h0000_0000, 16,  0, 1'b1};
        vecs[5] = '{32'hF000_0000, 29,  4, 1'b0};

        rst_n    = 1'b0;
        in_start = 1'b0;
        in_dio   = 1'b0;
        in_ref   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_scan(vecs[i].pass_map, vecs[i].exp_delay, vecs[i].exp_len,
                     vecs[i].exp_fail, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            m = $urandom;
            if (i % 2 == 1) m = m | (m >> 1) | (m >> 2);
            ref_model(m, d, len, fl);
            run_scan(m, d, len, fl, $sformatf("rnd%0d", i));
        end

        reset_mid_scan();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
